freq_channel_scheduler: RTL and testbench

//  Time-shares one frequency_counter datapath between NCH input signals. Scans enabled

---
 rtl/freq_channel_scheduler.sv | 174 +++++++++++++++++
 tb/tb_freq_channel_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_channel_scheduler.sv
// freq_channel_scheduler
//   Round-robin time-sharing of one frequency_counter across NCH inputs.
//   Per visit: switch the mux and hold the counter in reset for SETTLE cycles,
//   load the channel's gate period, wait for the counter's update pulse, then
//   store the edge count for that channel.
//   Optional build macro: FCS_TIMEOUT_EN adds a MEASURE watchdog that drops
//   a channel's valid flag and moves on when the counter never answers.
module freq_channel_scheduler #(
   parameter int NCH            = 4,
   parameter int CW             = 2,
   parameter int BITS           = 12,
   parameter int DEFAULT_PERIOD = 1200,
   parameter int SETTLE         = 4,
   parameter int TIMEOUT        = 8191
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NCH-1:0]  chan_en,
   input  logic            cfg_we,
   input  logic [CW-1:0]   cfg_chan,
   input  logic [BITS-1:0] cfg_period,
   output logic [CW-1:0]   sel,
   output logic            cnt_reset,
   output logic [BITS-1:0] period,
   output logic            period_load,
   input  logic            meas_done,
   input  logic [6:0]      meas_count,
   input  logic [CW-1:0]   rd_chan,
   output logic [6:0]      rd_data,
   output logic            rd_valid,
   output logic            scan_done
);

   localparam int SW = $clog2(SETTLE + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SWITCH,
      S_LOAD,
      S_MEASURE,
      S_STORE
   } state_t;

   state_t          state, state_nx;
   logic [SW-1:0]   settle_cnt;
   logic            settle_done;
   logic [BITS-1:0] period_reg [NCH];
   logic [6:0]      result     [NCH];
   logic [NCH-1:0]  valid;
   logic [CW-1:0]   first_from_sel;
   logic [CW-1:0]   first_after_sel;
   logic            any_en;
   logic            advance;
   logic            timeout_hit;

   // channel index base+k, wrapped into 0..NCH-1
   function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int k);
      int s;
      s = (int'(base) + k) % NCH;
      return CW'(s);
   endfunction

   // next-channel search: lowest offset wins, so scan offsets high to low
   always_comb begin
      first_from_sel  = sel;
      first_after_sel = sel;
      for (int k = NCH - 1; k >= 0; k--)
         if (chan_en[wrap_idx(sel, k)]) first_from_sel = wrap_idx(sel, k);
      for (int k = NCH; k >= 1; k--)
         if (chan_en[wrap_idx(sel, k)]) first_after_sel = wrap_idx(sel, k);
   end

   assign any_en      = |chan_en;
   assign settle_done = (settle_cnt == SW'(SETTLE - 1));

`ifdef FCS_TIMEOUT_EN
   logic [15:0] wd;

   // watchdog: cleared while loading, counts every MEASURE cycle
   always_ff @(posedge clk) begin
      if (reset)                  wd <= '0;
      else if (state == S_LOAD)   wd <= '0;
      else if (state == S_MEASURE) wd <= wd + 16'd1;
   end

   // a meas_done arriving on the limit cycle takes priority over the timeout
   assign timeout_hit = (state == S_MEASURE) && !meas_done && (wd == 16'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // a completed store and a watchdog expiry both move the scan on
   assign advance = (state == S_STORE) || timeout_hit;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // next state and per-state counter controls
   always_comb begin
      state_nx    = state;
      cnt_reset   = 1'b0;
      period_load = 1'b0;
      scan_done   = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_reset = 1'b1;
            if (any_en) state_nx = S_SWITCH;
         end
         S_SWITCH: begin
            cnt_reset = 1'b1;
            if (settle_done) state_nx = S_LOAD;
         end
         S_LOAD: begin
            period_load = 1'b1;
            state_nx    = S_MEASURE;
         end
         S_MEASURE: begin
            if (meas_done) state_nx = S_STORE;
         end
         S_STORE: begin
            state_nx = S_STORE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (advance) begin
         state_nx  = any_en ? S_SWITCH : S_IDLE;
         scan_done = any_en && (first_after_sel <= sel);
      end
   end

   // mux select, settle timer and period latch
   always_ff @(posedge clk) begin
      if (reset) begin
         sel        <= '0;
         settle_cnt <= '0;
         period     <= BITS'(DEFAULT_PERIOD);
      end else begin
         if (state == S_IDLE && any_en)  sel <= first_from_sel;
         else if (advance && any_en)     sel <= first_after_sel;
         settle_cnt <= (state == S_SWITCH) ? settle_cnt + SW'(1) : '0;
         // latch on the edge into LOAD so the value is stable for the whole visit
         if (state == S_SWITCH && settle_done) period <= period_reg[sel];
      end
   end

   // per-channel gate period registers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) period_reg[i] <= BITS'(DEFAULT_PERIOD);
      end else if (cfg_we) begin
         period_reg[cfg_chan] <= cfg_period;
      end
   end

   // per-channel results; a watchdog expiry invalidates but keeps the old count
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) result[i] <= '0;
         valid <= '0;
      end else if (state == S_STORE) begin
         result[sel] <= meas_count;
         valid[sel]  <= 1'b1;
      end else if (timeout_hit) begin
         valid[sel]  <= 1'b0;
      end
   end

   assign rd_data  = result[rd_chan];
   assign rd_valid = valid[rd_chan];

endmodule

// File: tb/tb_freq_channel_scheduler.sv
// Directed bench for freq_channel_scheduler with a small frequency_counter
// model: the model answers 4 cycles after a period load with a fixed count
// per channel (ch0=37, ch1=9, ch2=12, ch3=55).
module tb_freq_channel_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  chan_en;
   logic        cfg_we;
   logic [1:0]  cfg_chan;
   logic [11:0] cfg_period;
   logic [1:0]  sel;
   logic        cnt_reset;
   logic [11:0] period;
   logic        period_load;
   logic        meas_done;
   logic [6:0]  meas_count;
   logic [1:0]  rd_chan;
   logic [6:0]  rd_data;
   logic        rd_valid;
   logic        scan_done;

   int n_chk  = 0;
   int n_fail = 0;
   int n_load = 0;
   int sd_cnt = 0;
   int sd_sel = -1;
   logic silent = 1'b0;
   logic armed;
   int   mcnt;

   freq_channel_scheduler dut (
      .clk(clk), .reset(reset), .chan_en(chan_en), .cfg_we(cfg_we),
      .cfg_chan(cfg_chan), .cfg_period(cfg_period), .sel(sel),
      .cnt_reset(cnt_reset), .period(period), .period_load(period_load),
      .meas_done(meas_done), .meas_count(meas_count), .rd_chan(rd_chan),
      .rd_data(rd_data), .rd_valid(rd_valid), .scan_done(scan_done)
   );

   always #5 clk = ~clk;

   // counter model: per-channel constant count
   assign meas_count = (sel == 2'd0) ? 7'd37 : (sel == 2'd1) ? 7'd9 :
                       (sel == 2'd2) ? 7'd12 : 7'd55;

   // counter model: update pulse a few cycles after the load strobe
   always @(posedge clk) begin
      meas_done <= 1'b0;
      if (reset || cnt_reset) begin
         armed <= 1'b0;
         mcnt  <= 0;
      end else if (period_load) begin
         armed <= 1'b1;
         mcnt  <= 0;
      end else if (armed) begin
         if (mcnt == 3) begin
            meas_done <= !silent;
            armed     <= 1'b0;
         end else begin
            mcnt <= mcnt + 1;
         end
      end
   end

   // event monitor
   always @(negedge clk) begin
      if (period_load) n_load++;
      if (scan_done) begin
         sd_cnt++;
         sd_sel = int'(sel);
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // wait for the next load strobe; run = consecutive cnt_reset cycles before it
   task automatic wait_load(input int bound, output int run, output int cyc);
      bit hit;
      hit = 1'b0;
      run = 0;
      cyc = 0;
      while (!hit && cyc < bound) begin
         @(negedge clk);
         cyc++;
         if (period_load) hit = 1'b1;
         else if (cnt_reset) run++;
         else run = 0;
      end
      n_chk++;
      assert (hit) else begin
         n_fail++;
         $error("FAIL load_timeout observed=%0d expected=1", hit);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_sel"}, int'(sel), 0);
      chk({tag, "_cnt_reset"}, int'(cnt_reset), 1);
      chk({tag, "_period_load"}, int'(period_load), 0);
      chk({tag, "_period"}, int'(period), 1200);
      chk({tag, "_scan_done"}, int'(scan_done), 0);
   endtask

   initial begin
      int run, cyc;
      reset = 1'b1; chan_en = 4'b0000; cfg_we = 1'b0; cfg_chan = 2'd0;
      cfg_period = 12'd0; rd_chan = 2'd0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("rst0");
      chk("rst0_rd_valid", int'(rd_valid), 0);

      // no channel enabled: parked in IDLE
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("idle_loads", n_load, 0);
      chk("idle_cnt_reset", int'(cnt_reset), 1);
      chk("idle_sel", int'(sel), 0);

      // scan ch0 and ch2
      chan_en = 4'b0101;
      wait_load(50, run, cyc);
      chk("l1_sel", int'(sel), 0);
      chk("l1_period", int'(period), 1200);
      cfg_we = 1'b1; cfg_chan = 2'd2; cfg_period = 12'd600;
      @(negedge clk);
      cfg_we = 1'b0;

      wait_load(50, run, cyc);
      chk("l2_settle", run, 4);
      chk("l2_sel", int'(sel), 2);
      chk("l2_period", int'(period), 600);
      rd_chan = 2'd0;
      #1;
      chk("l2_rd_ch0", int'(rd_data), 37);
      chk("l2_rdv_ch0", int'(rd_valid), 1);
      chk("l2_scan_cnt", sd_cnt, 0);

      wait_load(50, run, cyc);
      chk("l3_sel", int'(sel), 0);
      chk("l3_period", int'(period), 1200);
      chk("l3_scan_cnt", sd_cnt, 1);
      chk("l3_scan_sel", sd_sel, 2);
      rd_chan = 2'd2;
      #1;
      chk("l3_rd_ch2", int'(rd_data), 12);
      chk("l3_rdv_ch2", int'(rd_valid), 1);
      rd_chan = 2'd1;
      #1;
      chk("l3_rdv_ch1", int'(rd_valid), 0);
      chk("l3_rd_ch1", int'(rd_data), 0);
      rd_chan = 2'd3;
      #1;
      chk("l3_rdv_ch3", int'(rd_valid), 0);
      // reprogram ch0 during its own measurement
      @(negedge clk);
      cfg_we = 1'b1; cfg_chan = 2'd0; cfg_period = 12'd300;
      @(negedge clk);
      cfg_we = 1'b0;
      chk("l3_period_held", int'(period), 1200);

      wait_load(50, run, cyc);
      chk("l4_sel", int'(sel), 2);
      chk("l4_period", int'(period), 600);
      wait_load(50, run, cyc);
      chk("l5_sel", int'(sel), 0);
      chk("l5_period", int'(period), 300);
      chk("l5_scan_cnt", sd_cnt, 2);

      // disable active ch0 mid-measure: it completes, then only ch3 runs
      @(negedge clk);
      chan_en = 4'b1000;
      wait_load(50, run, cyc);
      chk("l6_settle", run, 4);
      chk("l6_sel", int'(sel), 3);
      chk("l6_scan_cnt", sd_cnt, 2);
      wait_load(50, run, cyc);
      chk("l7_sel", int'(sel), 3);
      chk("l7_scan_cnt", sd_cnt, 3);
      chk("l7_scan_sel", sd_sel, 3);
      rd_chan = 2'd3;
      #1;
      chk("l7_rd_ch3", int'(rd_data), 55);
      chk("l7_rdv_ch3", int'(rd_valid), 1);

      // reset in the middle of a measurement
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_outputs("rst1");
      chk("rst1_rd_valid", int'(rd_valid), 0);
      chk("rst1_rd_data", int'(rd_data), 0);
      chan_en = 4'b0001;
      @(negedge clk);
      reset = 1'b0;
      wait_load(50, run, cyc);
      chk("l8_sel", int'(sel), 0);
      chk("l8_period", int'(period), 1200);

`ifdef FCS_TIMEOUT_EN
      // ch1 stops answering: watchdog drops valid and keeps the old count
      chan_en = 4'b0010;
      wait_load(50, run, cyc);
      chk("l9_sel", int'(sel), 1);
      wait_load(50, run, cyc);
      rd_chan = 2'd1;
      #1;
      chk("l10_rdv_ch1", int'(rd_valid), 1);
      silent = 1'b1;
      wait_load(9000, run, cyc);
      chk("wd_gap", cyc, 8196);
      chk("wd_rdv_ch1", int'(rd_valid), 0);
      chk("wd_rd_ch1", int'(rd_data), 9);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
